// File: rtl/tristate_bus_scheduler_if.sv
// Bundle of request, drive-data and resolved-bus signals between lane drivers
// and the tristate bus scheduler.
interface tristate_bus_scheduler_if #(
    parameter int N_REQ = 4,
    parameter int DW    = 8
);
    localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]    req;
    logic [N_REQ*DW-1:0] req_data;
    logic [N_REQ-1:0]    grant;
    logic [N_REQ-1:0]    drv_en;
    logic [DW-1:0]       bus_data;
    logic [1:0]          bus_strength;
    logic [OW-1:0]       bus_owner;
    logic                busy;

    modport master (
        output req, req_data,
        input  grant, drv_en, bus_data, bus_strength, bus_owner, busy
    );

    modport slave (
        input  req, req_data,
        output grant, drv_en, bus_data, bus_strength, bus_owner, busy
    );
endinterface

// File: rtl/tristate_bus_scheduler.sv
// Round-robin owner arbitration for a shared bus with high-Z turnaround and a
// trireg-style charge/decay model of the undriven net.
module tristate_bus_scheduler #(
    parameter int   N_REQ       = 4,
    parameter int   DW          = 8,
    parameter int   TURNAROUND  = 1,
    parameter int   MAX_BURST   = 8,
    parameter int   CHARGE_HOLD = 3,
    parameter logic PULL_VAL    = 1'b0
) (
    input logic clk,
    input logic rst,
    tristate_bus_scheduler_if.slave bus
);
    localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int TW = $clog2(TURNAROUND + 1);
    localparam int CW = (CHARGE_HOLD > 0) ? $clog2(CHARGE_HOLD + 1) : 1;

    typedef enum logic [1:0] {IDLE, DRIVE, TURN} state_t;
    typedef enum logic [1:0] {S_HIGHZ, S_CHARGE, S_PULL, S_STRONG} strength_t;

    state_t           state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [OW-1:0]    owner_q, owner_d;
    logic [OW-1:0]    rr_q, rr_d;
    logic [BW-1:0]    burst_q, burst_d;
    logic [TW-1:0]    turn_q, turn_d;
    logic [CW-1:0]    charge_q, charge_d;
    logic [DW-1:0]    last_q, last_d;

    logic [DW-1:0]    owner_data;
    logic             pick_vld, hi_vld, lo_vld, launch;
    logic [OW-1:0]    pick_idx, hi_idx, lo_idx;
    logic [DW-1:0]    bus_data_c;
    strength_t        strength_c;

    always_comb begin
        owner_data = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (owner_q == OW'(i)) owner_data = bus.req_data[i*DW +: DW];
        end
    end

    // Rotating priority: lowest requester at or above rr wins, else lowest overall (wrap).
    always_comb begin
        hi_vld = 1'b0;
        hi_idx = '0;
        lo_vld = 1'b0;
        lo_idx = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (bus.req[i] && !lo_vld) begin
                lo_vld = 1'b1;
                lo_idx = OW'(i);
            end
            if (bus.req[i] && OW'(i) >= rr_q && !hi_vld) begin
                hi_vld = 1'b1;
                hi_idx = OW'(i);
            end
        end
        pick_vld = lo_vld;
        pick_idx = hi_vld ? hi_idx : lo_idx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            owner_q  <= '0;
            rr_q     <= '0;
            burst_q  <= '0;
            turn_q   <= '0;
            charge_q <= '0;
            last_q   <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            owner_q  <= owner_d;
            rr_q     <= rr_d;
            burst_q  <= burst_d;
            turn_q   <= turn_d;
            charge_q <= charge_d;
            last_q   <= last_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        owner_d  = owner_q;
        rr_d     = rr_q;
        burst_d  = burst_q;
        turn_d   = turn_q;
        last_d   = last_q;
        launch   = 1'b0;
        charge_d = (state_q != DRIVE && charge_q != '0) ? charge_q - CW'(1) : charge_q;
        unique case (state_q)
            IDLE: launch = pick_vld;
            DRIVE: begin
                last_d = owner_data;
                if (!bus.req[owner_q] || burst_q == BW'(MAX_BURST)) begin
                    state_d  = TURN;
                    grant_d  = '0;
                    turn_d   = '0;
                    charge_d = CW'(CHARGE_HOLD);
                    rr_d     = (owner_q == OW'(N_REQ - 1)) ? '0 : owner_q + OW'(1);
                end else begin
                    burst_d = burst_q + BW'(1);
                end
            end
            TURN: begin
                if (turn_q == TW'(TURNAROUND - 1)) begin
                    launch  = pick_vld;
                    state_d = IDLE;
                end else begin
                    turn_d = turn_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        // Shared by IDLE and the last TURN cycle so both arbitrate identically.
        if (launch) begin
            state_d           = DRIVE;
            grant_d           = '0;
            grant_d[pick_idx] = 1'b1;
            owner_d           = pick_idx;
            burst_d           = BW'(1);
        end
    end

    always_comb begin
        bus_data_c = {DW{PULL_VAL}};
        strength_c = S_PULL;
        if (state_q == DRIVE) begin
            bus_data_c = owner_data;
            strength_c = S_STRONG;
        end else if (charge_q != '0) begin
            bus_data_c = last_q;
            strength_c = S_CHARGE;
        end
    end

    assign bus.grant        = grant_q;
    assign bus.drv_en       = grant_q;
    assign bus.bus_data     = bus_data_c;
    assign bus.bus_strength = strength_c;
    assign bus.bus_owner    = owner_q;
    assign bus.busy         = (state_q != IDLE);
endmodule

// File: tb/tb_tristate_bus_scheduler.sv
// Directed and random checks of tristate_bus_scheduler, with expected bus
// cycles queued as stimulus is applied.
module tb_tristate_bus_scheduler;
    localparam int N  = 4;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tristate_bus_scheduler_if #(.N_REQ(N), .DW(DW)) bus1 ();
    tristate_bus_scheduler_if #(.N_REQ(N), .DW(DW)) bus2 ();

    tristate_bus_scheduler #(
        .N_REQ(N), .DW(DW), .TURNAROUND(1), .MAX_BURST(8), .CHARGE_HOLD(3), .PULL_VAL(1'b0)
    ) u_dut (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    tristate_bus_scheduler #(
        .N_REQ(N), .DW(DW), .TURNAROUND(1), .MAX_BURST(8), .CHARGE_HOLD(0), .PULL_VAL(1'b1)
    ) u_dut2 (
        .clk(clk), .rst(rst), .bus(bus2)
    );

    typedef struct packed {
        logic [N-1:0]  grant;
        logic [1:0]    str;
        logic [DW-1:0] data;
        logic          busy;
    } exp_t;

    exp_t       sb[$];
    int         n_total = 0;
    int         n_fail  = 0;
    logic [7:0] lane [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input logic [N-1:0] g, input logic [1:0] s, input logic [DW-1:0] d,
                           input logic b);
        exp_t e;
        e.grant = g;
        e.str   = s;
        e.data  = d;
        e.busy  = b;
        sb.push_back(e);
    endtask

    task automatic step_sb(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_total++;
            n_fail++;
            $error("FAIL %s_sb_empty observed=empty expected=entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_grant"}, 32'(bus1.grant), 32'(e.grant));
            chk({tag, "_drv_en"}, 32'(bus1.drv_en), 32'(e.grant));
            chk({tag, "_strength"}, 32'(bus1.bus_strength), 32'(e.str));
            chk({tag, "_data"}, 32'(bus1.bus_data), 32'(e.data));
            chk({tag, "_busy"}, 32'(bus1.busy), 32'(e.busy));
        end
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [N-1:0]  g, prev_g, req_prev, mask;
        logic [DW-1:0] exp_d;
        logic          ok, fair_ok;
        int            waits [N];

        rst = 1'b1;
        lane[0] = 8'hA5;
        lane[1] = 8'h11;
        lane[2] = 8'h22;
        lane[3] = 8'h33;
        bus1.req      = '0;
        bus1.req_data = {lane[3], lane[2], lane[1], lane[0]};
        bus2.req      = '0;
        bus2.req_data = {8'h44, 8'h55, 8'h66, 8'h3C};
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_grant", 32'(bus1.grant), 32'h0);
        chk("rst_drv_en", 32'(bus1.drv_en), 32'h0);
        chk("rst_data", 32'(bus1.bus_data), 32'h00);
        chk("rst_strength", 32'(bus1.bus_strength), 32'd2);
        chk("rst_owner", 32'(bus1.bus_owner), 32'd0);
        chk("rst_busy", 32'(bus1.busy), 32'd0);
        chk("rst2_data", 32'(bus2.bus_data), 32'hFF);

        // Single requester, drop, charge retention then decay
        bus1.req = 4'b0001;
        sb_push(4'b0001, 2'd3, 8'hA5, 1'b1);
        step_sb("t1_drive");
        bus1.req = 4'b0000;
        sb_push(4'b0000, 2'd1, 8'hA5, 1'b1);
        sb_push(4'b0000, 2'd1, 8'hA5, 1'b0);
        sb_push(4'b0000, 2'd1, 8'hA5, 1'b0);
        sb_push(4'b0000, 2'd2, 8'h00, 1'b0);
        repeat (4) step_sb("t1_undriven");

        // All requesting: full bursts with one turnaround cycle between owners
        pulse_rst();
        bus1.req = 4'b1111;
        for (int unsigned k = 0; k < 5; k++) begin
            for (int unsigned c = 0; c < 8; c++) sb_push(4'(1 << (k % 4)), 2'd3, lane[k % 4], 1'b1);
            sb_push(4'b0000, 2'd1, lane[k % 4], 1'b1);
        end
        repeat (45) step_sb("t2_rr");
        bus1.req = 4'b0000;

        // Owner drops as another rises: turnaround first, rr resumes from 1
        pulse_rst();
        bus1.req = 4'b0101;
        sb_push(4'b0001, 2'd3, 8'hA5, 1'b1);
        step_sb("t3_first");
        bus1.req = 4'b0110;
        sb_push(4'b0000, 2'd1, 8'hA5, 1'b1);
        sb_push(4'b0010, 2'd3, 8'h11, 1'b1);
        repeat (2) step_sb("t3_handover");
        chk("t3_owner", 32'(bus1.bus_owner), 32'd1);

        // Asynchronous reset in the middle of a drive
        #2;
        rst = 1'b1;
        #1;
        chk("t5_grant", 32'(bus1.grant), 32'h0);
        chk("t5_drv_en", 32'(bus1.drv_en), 32'h0);
        chk("t5_strength", 32'(bus1.bus_strength), 32'd2);
        chk("t5_data", 32'(bus1.bus_data), 32'h00);
        chk("t5_busy", 32'(bus1.busy), 32'd0);
        chk("t5_owner", 32'(bus1.bus_owner), 32'd0);
        rst = 1'b0;
        bus1.req = 4'b0011;
        sb_push(4'b0001, 2'd3, 8'hA5, 1'b1);
        step_sb("t5_rr_zero");
        bus1.req = 4'b0000;
        repeat (6) @(posedge clk);
        #1;

        // No charge retention, pull-up to all ones
        bus2.req = 4'b0001;
        @(posedge clk);
        #1;
        chk("t4_grant", 32'(bus2.grant), 32'h1);
        chk("t4_drive_data", 32'(bus2.bus_data), 32'h3C);
        chk("t4_drive_str", 32'(bus2.bus_strength), 32'd3);
        bus2.req = 4'b0000;
        @(posedge clk);
        #1;
        chk("t4_turn_grant", 32'(bus2.grant), 32'h0);
        chk("t4_turn_data", 32'(bus2.bus_data), 32'hFF);
        chk("t4_turn_str", 32'(bus2.bus_strength), 32'd2);
        chk("t4_turn_busy", 32'(bus2.busy), 32'd1);

        // Random traffic: invariants, turnaround gaps and round-robin fairness
        pulse_rst();
        prev_g = '0;
        for (int unsigned i = 0; i < N; i++) waits[i] = 0;
        for (int unsigned c = 0; c < 10000; c++) begin
            req_prev = bus1.req;
            @(posedge clk);
            #1;
            g = bus1.grant;
            exp_d = '0;
            for (int unsigned i = 0; i < N; i++) begin
                if (g[i]) exp_d = bus1.req_data[i*DW +: DW];
            end
            ok = $onehot0(g) && (bus1.drv_en === g) && ((g != '0) == (bus1.bus_strength == 2'd3))
                 && !(prev_g != '0 && g != '0 && g != prev_g)
                 && (g == '0 || bus1.bus_data === exp_d);
            chk("t6_invariant", 32'(ok), 32'd1);
            for (int unsigned i = 0; i < N; i++) begin
                if (!req_prev[i]) waits[i] = 0;
            end
            if (g != '0 && prev_g == '0) begin
                fair_ok = 1'b1;
                for (int unsigned i = 0; i < N; i++) begin
                    if (g[i]) waits[i] = 0;
                    else if (req_prev[i]) waits[i]++;
                    if (waits[i] > N - 1) fair_ok = 1'b0;
                end
                chk("t6_fairness", 32'(fair_ok), 32'd1);
            end
            prev_g = g;
            mask = '0;
            for (int unsigned i = 0; i < N; i++) begin
                if ($urandom_range(7) == 0) mask[i] = 1'b1;
            end
            bus1.req      = bus1.req ^ mask;
            bus1.req_data = 32'($urandom);
        end

        $display("%0d/%0d checks passed", n_total - n_fail, n_total);
        $finish;
    end
endmodule
